// File: rtl/pkt_rr_arbiter.sv
// Round-robin output-port arbiter for one router output. It locks onto one input
// buffer for a whole packet, and the downstream packet_tracker decides when to release it.
module pkt_rr_arbiter #(
   parameter  int NUM_PORTS  = 5,
   parameter  int DATA_WIDTH = 8,
   localparam int PW         = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            req_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
   output logic [NUM_PORTS-1:0]            grant_o,
   output logic                            valid_o,
   output logic [DATA_WIDTH-1:0]           data_o,
   input  logic                            ready_i,
   output logic                            pt_inc_o,
   input  logic                            pt_end_i,
   input  logic                            pt_empty_i,
   output logic [PW-1:0]                   owner_o,
   output logic                            err_o
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                  state_r;
   logic [PW-1:0]           owner_r;
   logic [PW-1:0]           last_ptr_r;
   logic                    err_r;
   logic [PW-1:0]           winner_s;
   logic                    found_s;
   logic [PW-1:0]           idx_s;
   logic [DATA_WIDTH-1:0]   owner_data_s;

   // Round-robin search starting just after the last owner, so the last owner ranks lowest.
   always_comb begin
      winner_s = {PW{1'b0}};
      found_s  = 1'b0;
      idx_s    = {PW{1'b0}};
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx_s = PW'((int'(last_ptr_r) + i) % NUM_PORTS);
         if (!found_s && req_i[idx_s]) begin
            found_s  = 1'b1;
            winner_s = idx_s;
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Flit mux of the current owner's buffer.
   always_comb begin
      owner_data_s = {DATA_WIDTH{1'b0}};
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (owner_r == PW'(k)) begin
            owner_data_s = data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            owner_data_s = owner_data_s;
         end
      end
   end

   // Arbitration FSM: the winner is registered in IDLE, and the lock is released on the tracker's end cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         owner_r    <= {PW{1'b0}};
         last_ptr_r <= PW'(NUM_PORTS - 1);
         err_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // A non-empty tracker or a stray end pulse between packets is a protocol breach.
               if (!pt_empty_i || pt_end_i) begin
                  err_r <= 1'b1;
               end
               if (found_s) begin
                  owner_r <= winner_s;
                  state_r <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (pt_end_i) begin
                  last_ptr_r <= owner_r;
                  state_r    <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Output link, pop strobe and tracker increment follow the locked owner combinationally.
   always_comb begin
      valid_o  = 1'b0;
      grant_o  = {NUM_PORTS{1'b0}};
      pt_inc_o = 1'b0;
      data_o   = {DATA_WIDTH{1'b0}};
      case (state_r)
         ST_LOCKED: begin
            data_o = owner_data_s;
            if (!pt_end_i) begin
               valid_o = req_i[owner_r];
               if (req_i[owner_r] && ready_i) begin
                  grant_o[owner_r] = 1'b1;
                  pt_inc_o         = 1'b1;
               end else begin
                  pt_inc_o = 1'b0;
               end
            end else begin
               valid_o = 1'b0;
            end
         end
         ST_IDLE: begin
            valid_o = 1'b0;
         end
         default: begin
            valid_o = 1'b0;
         end
      endcase
   end

   assign owner_o = owner_r;
   assign err_o   = err_r;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter. A 4-flit packet_tracker model closes the
// pt_inc/pt_end/pt_empty loop, and every check goes through one compare task.
module tb_pkt_rr_arbiter;

   localparam int NP = 5;
   localparam int DW = 8;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [NP-1:0]        req_i = '0;
   logic [NP*DW-1:0]     data_i = '0;
   logic [NP-1:0]        grant_o;
   logic                 valid_o;
   logic [DW-1:0]        data_o;
   logic                 ready_i = 1'b1;
   logic                 pt_inc_o;
   logic                 pt_end_i;
   logic                 pt_empty_i;
   logic [2:0]           owner_o;
   logic                 err_o;

   logic                 force_empty = 1'b0;
   logic [2:0]           pt_cnt;
   int                   inc_cnt = 0;
   int                   n_cmp = 0;
   int                   n_bad = 0;
   int                   base;

   pkt_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_i      (req_i),
      .data_i     (data_i),
      .grant_o    (grant_o),
      .valid_o    (valid_o),
      .data_o     (data_o),
      .ready_i    (ready_i),
      .pt_inc_o   (pt_inc_o),
      .pt_end_i   (pt_end_i),
      .pt_empty_i (pt_empty_i),
      .owner_o    (owner_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   // packet_tracker: updates one cycle after inc, holds 4 for one cycle, drops an inc at 4
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pt_cnt <= 3'd0;
      end else if (pt_cnt == 3'd4) begin
         pt_cnt <= 3'd0;
      end else if (pt_inc_o) begin
         pt_cnt <= pt_cnt + 3'd1;
      end
   end
   assign pt_end_i   = (pt_cnt == 3'd4);
   assign pt_empty_i = force_empty ? 1'b0 : (pt_cnt == 3'd0);

   always @(negedge clk) begin
      if (pt_inc_o === 1'b1) inc_cnt <= inc_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_data(input int k, input logic [DW-1:0] v);
      data_i[k*DW +: DW] = v;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_valid"}, 32'(valid_o), 32'd0);
      chk({tag, "_grant"}, 32'(grant_o), 32'd0);
      chk({tag, "_inc"}, 32'(pt_inc_o), 32'd0);
   endtask

   task automatic chk_xfer(input string tag, input logic [NP-1:0] g, input logic [DW-1:0] d);
      chk({tag, "_valid"}, 32'(valid_o), 32'd1);
      chk({tag, "_grant"}, 32'(grant_o), 32'(g));
      chk({tag, "_inc"}, 32'(pt_inc_o), 32'd1);
      chk({tag, "_data"}, 32'(data_o), 32'(d));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_i = '0;
      ready_i = 1'b1;
      force_empty = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int exp_own [6] = '{0, 1, 2, 3, 4, 0};
      logic [NP-1:0] g;

      // Reset state
      #3;
      settle();
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_inc", 32'(pt_inc_o), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_owner", 32'(owner_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);

      // Single packet on port 0
      do_reset();
      req_i = 5'b00001;
      set_data(0, 8'hA1);
      settle();
      chk_quiet("t1_idle");
      tick();
      for (int f = 1; f <= 4; f++) begin
         set_data(0, 8'(8'hA0 + f));
         settle();
         chk_xfer("t1_flit", 5'b00001, 8'(8'hA0 + f));
         chk("t1_owner", 32'(owner_o), 32'd0);
         tick();
      end
      req_i = 5'b00000;
      settle();
      chk_quiet("t1_end");
      tick();
      req_i = 5'b00001;
      settle();
      chk_quiet("t1_back_idle");
      chk("t1_idle_data", 32'(data_o), 32'd0);
      chk("t1_idle_owner", 32'(owner_o), 32'd0);
      chk("t1_err", 32'(err_o), 32'd0);

      // All ports requesting: strict rotation with 6-cycle spacing
      do_reset();
      req_i = 5'b11111;
      for (int k = 0; k < NP; k++) set_data(k, 8'(8'h30 + k));
      base = inc_cnt;
      for (int p = 0; p < 6; p++) begin
         settle();
         chk_quiet("t2_idle");
         tick();
         g = NP'(1) << exp_own[p];
         for (int f = 0; f < 4; f++) begin
            settle();
            chk_xfer("t2_flit", g, 8'(8'h30 + exp_own[p]));
            chk("t2_owner", 32'(owner_o), 32'(exp_own[p]));
            tick();
         end
         settle();
         chk_quiet("t2_end");
         if (p == 4) chk("t2_inc_total", 32'(inc_cnt - base), 32'd20);
         tick();
      end

      // Port 2 with a 3-cycle downstream stall after flit 2
      do_reset();
      req_i = 5'b00100;
      base = inc_cnt;
      settle();
      chk_quiet("t3_idle");
      tick();
      for (int f = 1; f <= 2; f++) begin
         set_data(2, 8'(8'hC0 + f));
         settle();
         chk_xfer("t3_flit", 5'b00100, 8'(8'hC0 + f));
         tick();
      end
      set_data(2, 8'hC3);
      ready_i = 1'b0;
      for (int s = 0; s < 3; s++) begin
         settle();
         chk("t3_stall_valid", 32'(valid_o), 32'd1);
         chk("t3_stall_grant", 32'(grant_o), 32'd0);
         chk("t3_stall_inc", 32'(pt_inc_o), 32'd0);
         chk("t3_stall_data", 32'(data_o), 32'hC3);
         tick();
      end
      ready_i = 1'b1;
      for (int f = 3; f <= 4; f++) begin
         set_data(2, 8'(8'hC0 + f));
         settle();
         chk_xfer("t3_resume", 5'b00100, 8'(8'hC0 + f));
         tick();
      end
      settle();
      chk_quiet("t3_end");
      chk("t3_inc_total", 32'(inc_cnt - base), 32'd4);

      // Port 1 locked, port 3 requests mid-packet and must wait
      do_reset();
      req_i = 5'b00010;
      set_data(1, 8'h51);
      set_data(3, 8'h73);
      settle();
      chk_quiet("t4_idle");
      tick();
      settle();
      chk_xfer("t4_flit1", 5'b00010, 8'h51);
      tick();
      req_i = 5'b01010;
      for (int f = 2; f <= 4; f++) begin
         settle();
         chk_xfer("t4_flit", 5'b00010, 8'h51);
         tick();
      end
      settle();
      chk_quiet("t4_end");
      tick();
      settle();
      chk_quiet("t4_rearb");
      tick();
      settle();
      chk("t4_owner", 32'(owner_o), 32'd3);
      chk_xfer("t4_p3", 5'b01000, 8'h73);

      // Async reset in the middle of a port-4 packet
      do_reset();
      req_i = 5'b10000;
      set_data(4, 8'h94);
      set_data(0, 8'h05);
      settle();
      tick();
      for (int f = 1; f <= 2; f++) begin
         settle();
         chk_xfer("t5_flit", 5'b10000, 8'h94);
         tick();
      end
      #4;
      reset = 1'b1;
      #1;
      chk("t5_ar_valid", 32'(valid_o), 32'd0);
      chk("t5_ar_grant", 32'(grant_o), 32'd0);
      chk("t5_ar_inc", 32'(pt_inc_o), 32'd0);
      chk("t5_ar_data", 32'(data_o), 32'd0);
      chk("t5_ar_owner", 32'(owner_o), 32'd0);
      chk("t5_ar_err", 32'(err_o), 32'd0);
      tick();
      reset = 1'b0;
      req_i = 5'b10001;
      settle();
      chk_quiet("t5_idle");
      tick();
      settle();
      chk("t5_owner", 32'(owner_o), 32'd0);
      chk_xfer("t5_p0", 5'b00001, 8'h05);

      // Non-empty tracker seen while idle sets the sticky error
      do_reset();
      settle();
      chk("t6_err0", 32'(err_o), 32'd0);
      force_empty = 1'b1;
      settle();
      chk("t6_err_same", 32'(err_o), 32'd0);
      tick();
      force_empty = 1'b0;
      settle();
      chk("t6_err_set", 32'(err_o), 32'd1);
      tick();
      tick();
      settle();
      chk("t6_err_hold", 32'(err_o), 32'd1);
      do_reset();
      settle();
      chk("t6_err_clr", 32'(err_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Round-robin output-port arbiter for one NOC router output.
- Grants one of NUM_PORTS input buffers and holds the grant for a whole packet, muxing that buffer's flits to the output link.
- Sits directly upstream of packet_tracker, which counts the packet's flits:
  - Drives the tracker's pt_inc_i.
  - Consumes the tracker's pt_end_o and pt_empty_o to decide when to release the lock.

Parameters:
- NUM_PORTS, 5, number of requesting input buffers (N, S, E, W, local).
- DATA_WIDTH, 8, flit width in bits.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  NUM_PORTS  per-input "flit available" (input buffer not empty).
- data_i  in  NUM_PORTS*DATA_WIDTH  flattened flits; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- grant_o  out  NUM_PORTS  one-hot pop strobe to the owning input buffer; high only on a transfer cycle.
- valid_o  out  1  output flit valid.
- data_o  out  DATA_WIDTH  output flit.
- ready_i  in  1  downstream accepts a flit this cycle.
- pt_inc_o  out  1  to packet_tracker pt_inc_i; one pulse per transferred flit.
- pt_end_i  in  1  from packet_tracker pt_end_o; count==4, packet complete.
- pt_empty_i  in  1  from packet_tracker pt_empty_o; count==0.
- owner_o  out  $clog2(NUM_PORTS)  current/last owner index (debug).
- err_o  out  1  sticky protocol error.

Behaviour:
- Packet length: fixed 4 flits, as counted by packet_tracker. The tracker:
  - Updates one cycle after pt_inc.
  - Holds count 4 for exactly one cycle, then clears.
  - Drops an inc presented while at 4.
- FSM states:
  - IDLE: no output activity.
    - If any req_i bit is set, select the winner by round robin, searching from (last_ptr+1) mod NUM_PORTS upward with wrap.
    - Register the winner as owner; next state LOCKED.
    - The grant decision is registered, so no transfer occurs in the IDLE cycle.
  - LOCKED, with pt_end_i=0:
    - valid_o = req_i[owner].
    - data_o = data_i slice of owner.
    - Transfer = valid_o & ready_i.
    - On a transfer: grant_o[owner]=1 and pt_inc_o=1. No other grant_o bit is ever high.
  - LOCKED, with pt_end_i=1:
    - valid_o, grant_o and pt_inc_o are forced 0.
    - last_ptr <= owner; next state IDLE.
- Requests from non-owners during LOCKED are ignored. An owner deasserting req_i mid-packet stalls the packet; the lock is kept.
- ready_i low stalls with no inc and no pop; data_o stays equal to the owner's data_i.
- Latency/throughput:
  - First flit can transfer 1 cycle after req_i is seen in IDLE.
  - Minimum packet occupancy is 6 cycles: 1 IDLE + 4 transfers + 1 pt_end cycle.
- err_o is set, and held until reset, on any of:
  - pt_empty_i=0 while in IDLE.
  - pt_end_i=1 while in IDLE.
- Wrap-around: when owner=NUM_PORTS-1, the next search starts at port 0.
- Simultaneous requests: the lowest index at or after last_ptr+1 wins. The last owner gets lowest priority.
- Reset (async, any time, including mid-packet):
  - state=IDLE, owner=0, last_ptr=NUM_PORTS-1 (so port 0 has top priority).
  - err_o=0.
  - All outputs 0: valid_o, grant_o, pt_inc_o, data_o.
  - The tracker is reset by the same signal, so no partial packet survives.
- data_o is 0 whenever not LOCKED. Outputs are combinational from state/owner and inputs; there is no flit register.

Test Plan:
- Reset, then req_i=5'b00001, ready_i=1, 4-flit packet A1..A4 on port 0:
  - LOCKED at cycle 1.
  - grant_o=00001 and pt_inc_o=1 on cycles 1-4, data_o=A1..A4.
  - pt_end_i at cycle 5 with valid_o=0.
  - IDLE at cycle 6, owner_o=0.
- req_i=5'b11111 held, ready_i=1:
  - Owners in order 0,1,2,3,4,0.
  - Each packet 4 grants, 6-cycle spacing, exactly 20 pt_inc pulses over the first 5 packets.
- Port 2 locked, ready_i=0 for 3 cycles after flit 2:
  - No grant_o and no pt_inc_o during the stall; data_o holds flit 3.
  - On resume, flits 3-4 complete, total 4 pt_inc.
- Port 1 locked; port 3 asserts req_i mid-packet:
  - No grant to port 3 until port 1's pt_end_i cycle passes.
  - Port 3 is then granted next (last_ptr=1).
- Assert reset asynchronously after flit 2 of a port-4 packet:
  - All outputs 0 immediately; tracker cleared; err_o=0.
  - After release, port 0 wins over port 4 when both request.
- Force pt_empty_i=0 in IDLE for one cycle:
  - err_o=1 from the next cycle and stays 1 until reset.
